// File: rtl/wb_pipe_slave_adapter_pkg.sv
// Shared types and helpers for the Wishbone pipelined slave adapter.
// The tag records how the head of the outstanding queue must be answered.
package wb_adapter_pkg;

   typedef enum logic {
      TAG_FWD       = 1'b0,
      TAG_LOCAL_ERR = 1'b1
   } resp_tag_e;

   // Aborts and timeouts can leave up to 2*depth responses owed by the native side.
   function automatic int disc_cnt_width(int max_outstanding);
      return $clog2(2 * max_outstanding) + 1;
   endfunction

   // One extra bit keeps base+size from wrapping at the top of the address space.
   function automatic logic in_window(logic [63:0] addr, logic [63:0] base, logic [63:0] size);
      logic [64:0] a;
      logic [64:0] lo;
      logic [64:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + {1'b0, size};
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/wb_pipe_slave_adapter_if.sv
// Bus bundles for the adapter: Wishbone B4 pipelined side and native register side.
// The native side: reg_req/reg_gnt transfer a request; reg_rvalid is held until reg_rready.
interface wb_pipe_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   wb_adr_i;
   logic [DATA_WIDTH-1:0]   wb_dat_i;
   logic [DATA_WIDTH-1:0]   wb_dat_o;
   logic                    wb_we_i;
   logic [DATA_WIDTH/8-1:0] wb_sel_i;
   logic                    wb_stb_i;
   logic                    wb_cyc_i;
   logic                    wb_ack_o;
   logic                    wb_err_o;
   logic                    wb_stall_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
   );
endinterface

interface reg_bus_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    reg_req;
   logic                    reg_gnt;
   logic [ADDR_WIDTH-1:0]   reg_addr;
   logic [DATA_WIDTH-1:0]   reg_wdata;
   logic                    reg_we;
   logic [DATA_WIDTH/8-1:0] reg_be;
   logic                    reg_rvalid;
   logic [DATA_WIDTH-1:0]   reg_rdata;
   logic                    reg_rerr;
   logic                    reg_rready;

   modport master (
      output reg_req, reg_addr, reg_wdata, reg_we, reg_be, reg_rready,
      input  reg_gnt, reg_rvalid, reg_rdata, reg_rerr
   );

   modport slave (
      input  reg_req, reg_addr, reg_wdata, reg_we, reg_be, reg_rready,
      output reg_gnt, reg_rvalid, reg_rdata, reg_rerr
   );
endinterface

// File: rtl/wb_pipe_slave_adapter_tag_fifo.sv
// Small synchronous FIFO holding one response tag per outstanding Wishbone request.
// Flush has priority over push and pop; DEPTH must be a power of two.
module wb_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && !full;
      do_pop   = pop && !empty;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/wb_pipe_slave_adapter.sv
// Wishbone B4 pipelined slave bridged onto a native request/grant, valid/ready register bus.
// Keeps responses in order, answers unmapped addresses locally and recovers from timeouts/aborts.
module wb_pipe_slave_adapter
   import wb_adapter_pkg::*;
#(
   parameter int                    ADDR_WIDTH      = 32,
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    MAX_OUTSTANDING = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter longint unsigned       WINDOW_SIZE     = 4096,
   parameter int                    TIMEOUT_CYCLES  = 255
) (
   input  logic      wb_clk_i,
   input  logic      wb_rst_i,
   wb_pipe_if.slave  wb,
   reg_bus_if.master rb
);
   localparam int DISC_W = disc_cnt_width(MAX_OUTSTANDING);
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
   localparam int WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic                  mapped, full, disc_idle, accept, abort;
   logic                  head_valid, head_fwd, head_local, bypass;
   logic                  rsp_taken, head_rsp, timeout, pop_head;
   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [0:0]            fifo_rdata;
   logic [CNT_W-1:0]      fifo_count;
   resp_tag_e             push_tag, head_tag;

   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;
   logic [DISC_W-1:0]     disc_q, disc_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [CNT_W-1:0]      fwd_q, fwd_d;

   assign rb.reg_addr  = wb.wb_adr_i;
   assign rb.reg_wdata = wb.wb_dat_i;
   assign rb.reg_we    = wb.wb_we_i;
   assign rb.reg_be    = wb.wb_sel_i;
   assign wb.wb_ack_o  = ack_q;
   assign wb.wb_err_o  = err_q;
   assign wb.wb_dat_o  = dat_q;

   // Request side and head selection; an empty queue lets the incoming tag act as head.
   always_comb begin
      mapped     = in_window(64'(wb.wb_adr_i), 64'(BASE_ADDR), 64'(WINDOW_SIZE));
      full       = (fifo_count == CNT_W'(MAX_OUTSTANDING));
      disc_idle  = (disc_q == '0);
      rb.reg_req = wb.wb_cyc_i && wb.wb_stb_i && mapped && !full && disc_idle;
      wb.wb_stall_o = wb.wb_cyc_i && wb.wb_stb_i &&
                      (full || !disc_idle || (mapped && !rb.reg_gnt));
      accept     = wb.wb_cyc_i && wb.wb_stb_i && !wb.wb_stall_o;
      push_tag   = mapped ? TAG_FWD : TAG_LOCAL_ERR;
      abort      = !wb.wb_cyc_i && !fifo_empty;
      bypass     = fifo_empty && accept;
      head_valid = !fifo_empty || accept;
      head_tag   = fifo_empty ? push_tag : resp_tag_e'(fifo_rdata);
      head_fwd   = head_valid && (head_tag == TAG_FWD) && disc_idle;
      head_local = head_valid && (head_tag == TAG_LOCAL_ERR) && disc_idle;
      rb.reg_rready = !disc_idle || head_fwd;
      rsp_taken  = rb.reg_rready && rb.reg_rvalid;
      head_rsp   = head_fwd && rb.reg_rvalid;
      timeout    = head_fwd && !rb.reg_rvalid && (TIMEOUT_CYCLES != 0) &&
                   (wait_q == WAIT_W'(TIMEOUT_CYCLES));
      pop_head   = head_local || head_rsp || timeout;
      fifo_push  = accept && !(bypass && pop_head);
      fifo_pop   = pop_head && !fifo_empty;
   end

   // Response side: bookkeeping counters and the registered Wishbone response.
   always_comb begin
      wait_d = wait_q;
      fwd_d  = fwd_q;
      disc_d = disc_q;
      ack_d  = 1'b0;
      err_d  = 1'b0;
      dat_d  = dat_q;
      if (abort || pop_head) begin
         wait_d = '0;
      end else if (head_fwd && (TIMEOUT_CYCLES != 0)) begin
         wait_d = wait_q + WAIT_W'(1);
      end
      if (abort) begin
         fwd_d  = '0;
         // Every flushed FWD entry still owes a native response, minus one taken now.
         disc_d = disc_q + DISC_W'(fwd_q) - DISC_W'(rsp_taken);
      end else begin
         fwd_d  = fwd_q + CNT_W'(fifo_push && (push_tag == TAG_FWD))
                        - CNT_W'(fifo_pop && (head_tag == TAG_FWD));
         disc_d = disc_q + DISC_W'(timeout) - DISC_W'(rsp_taken && !disc_idle);
         ack_d  = head_rsp && !rb.reg_rerr;
         err_d  = head_local || timeout || (head_rsp && rb.reg_rerr);
         if (head_rsp) dat_d = rb.reg_rdata;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         dat_q  <= '0;
         disc_q <= '0;
         wait_q <= '0;
         fwd_q  <= '0;
      end else begin
         ack_q  <= ack_d;
         err_q  <= err_d;
         dat_q  <= dat_d;
         disc_q <= disc_d;
         wait_q <= wait_d;
         fwd_q  <= fwd_d;
      end
   end

   wb_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (1)
   ) u_tag_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (abort),
      .wdata (push_tag),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   a_fifo_flags: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
      (fifo_full == full) && (fifo_empty == (fifo_count == '0)));
   a_disc_no_overflow: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
      (32'(disc_q) <= 2 * MAX_OUTSTANDING));
endmodule
